bram_dp: RTL and testbench

Parametrised simple-dual-port block RAM for the ABP datapath: one write port with byte enables, one read port with a registered one-cycle read. After every reset it runs a hardware clear sequence that zeroes the full array. It buffers frame payloads between the ABP sender/receiver logic and the link. Depth is exactly 2**ADDRESS_WIDTH words, and read-during-write collisions resolve in a selectable mode.

---
 rtl/bram_dp.sv | 181 ++++++++++++++++++
 tb/tb_bram_dp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_dp.sv
`timescale 1ns/1ps
// bram_dp: simple-dual-port block RAM with byte-enable writes, a registered one-cycle read and a
// post-reset hardware clear of the whole array. Define BRAM_PARITY_EN for per-lane even parity.
module bram_dp #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RDW_MODE      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDRESS_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
`ifdef BRAM_PARITY_EN
  input  logic                      wr_par_inject,
  output logic [DATA_WIDTH/8-1:0]   rd_par_err,
`endif
  input  logic                      rd_en,
  input  logic [ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      init_busy
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDRESS_WIDTH-1:0]  clr_addr;
  logic [ADDRESS_WIDTH-1:0]  clr_addr_nxt;

  // Single internal write port shared by the clear sequence and user writes.
  logic [NB-1:0]             lane_we;
  logic [ADDRESS_WIDTH-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      rd_accept;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [DATA_WIDTH-1:0]     old_word;
  logic [DATA_WIDTH-1:0]     merged_word;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      collide;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and write-port steering
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    lane_we      = '0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    rd_accept    = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        lane_we      = '1;
        mem_waddr    = clr_addr;
        mem_wdata    = '0;
        clr_addr_nxt = clr_addr + ADDRESS_WIDTH'(1);
        if (&clr_addr) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (wr_en) lane_we = wr_be;
        rd_accept = rd_en;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign init_busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Data array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto block RAM; the clear FSM zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Write-first bypass: the word the array will hold after this edge's write.
  always_comb begin
    old_word    = mem[rd_addr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) merged_word[8*i +: 8] = mem_wdata[8*i +: 8];
    end
    collide = (|lane_we) && (mem_waddr == rd_addr);
    rd_word = (RDW_MODE == 1 && collide) ? merged_word : old_word;
  end

`ifdef BRAM_PARITY_EN
  // ---------------------------------------------------------------------------
  // Parity: one even-parity bit per lane, inverted on write when injection is requested
  // ---------------------------------------------------------------------------
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_wdata;
  logic [NB-1:0] old_par;
  logic [NB-1:0] rd_par;
  logic [NB-1:0] par_err_nxt;
  logic          inject;

  assign inject = (state == ST_READY) && wr_par_inject;

  always_comb begin
    par_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      par_wdata[i] = (^mem_wdata[8*i +: 8]) ^ inject;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[i]) par_mem[mem_waddr][i] <= par_wdata[i];
      end
    end
  end

  always_comb begin
    old_par     = par_mem[rd_addr];
    rd_par      = old_par;
    par_err_nxt = '0;
    if (RDW_MODE == 1 && collide) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[i]) rd_par[i] = par_wdata[i];
      end
    end
    for (int i = 0; i < NB; i++) begin
      par_err_nxt[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_par_err <= '0;
    end else if (rd_accept) begin
      rd_par_err <= par_err_nxt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_bram_dp.sv
`timescale 1ns/1ps
// tb_bram_dp: drives a read-first and a write-first bram_dp from shared stimulus and checks both
// against a word-level array model that also tracks the clear sequence and injected parity lanes.
module tb_bram_dp;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          par_inject;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          init_busy0, init_busy1;
`ifdef BRAM_PARITY_EN
  logic [NB-1:0] rd_par_err0, rd_par_err1;
`endif

  always #5 clk = ~clk;

  bram_dp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0)) dut_rf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
`ifdef BRAM_PARITY_EN
    .wr_par_inject(par_inject), .rd_par_err(rd_par_err0),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0)
  );

  bram_dp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1)) dut_wf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
`ifdef BRAM_PARITY_EN
    .wr_par_inject(par_inject), .rd_par_err(rd_par_err1),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
  );

  // Reference model: array contents, which lanes hold injected parity, clear edges still owed.
  logic [DW-1:0] model_mem [DEPTH];
  logic [NB-1:0] model_bad [DEPTH];
  int            clr_left = DEPTH;
  logic [DW-1:0] exp_data0 = '0, exp_data1 = '0;
  logic [NB-1:0] exp_err0 = '0, exp_err1 = '0;
  logic          exp_valid = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // One clock edge: drive, predict, wait for the edge, then compare every output.
  task automatic cycle(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [NB-1:0] be,
                       input logic re, input logic [AW-1:0] ra, input logic inj);
    logic [DW-1:0] old_w;
    logic [NB-1:0] old_b;
    rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; par_inject = inj;

    if (!rst) begin
      clr_left  = DEPTH;
      exp_valid = 1'b0;
      exp_data0 = '0; exp_data1 = '0;
      exp_err0  = '0; exp_err1  = '0;
    end else if (clr_left > 0) begin
      model_mem[DEPTH - clr_left] = '0;
      model_bad[DEPTH - clr_left] = '0;
      clr_left--;
      exp_valid = 1'b0;
    end else begin
      old_w = model_mem[ra];
      old_b = model_bad[ra];
      if (we) begin
        model_mem[wa] = merge(model_mem[wa], wd, be);
        for (int i = 0; i < NB; i++) if (be[i]) model_bad[wa][i] = inj;
      end
      exp_valid = re;
      if (re) begin
        exp_data0 = old_w;          exp_err0 = old_b;
        exp_data1 = model_mem[ra];  exp_err1 = model_bad[ra];
      end
    end

    @(posedge clk);
    #1;
    check("busy_rf",  32'(init_busy0), 32'(clr_left > 0));
    check("busy_wf",  32'(init_busy1), 32'(clr_left > 0));
    check("valid_rf", 32'(rd_valid0),  32'(exp_valid));
    check("valid_wf", 32'(rd_valid1),  32'(exp_valid));
    check("data_rf",  rd_data0, exp_data0);
    check("data_wf",  rd_data1, exp_data1);
`ifdef BRAM_PARITY_EN
    check("perr_rf", 32'(rd_par_err0), 32'(exp_err0));
    check("perr_wf", 32'(rd_par_err1), 32'(exp_err1));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be,
                    input logic inj);
    cycle(1'b1, 1'b1, a, d, be, 1'b0, '0, inj);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, a, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end

    // Reset, then exactly DEPTH busy edges; every address reads zero.
    do_reset(2);
    idle(DEPTH - 1);
    check("busy_at_63", 32'(init_busy0), 32'd1);
    idle(1);
    check("busy_at_64", 32'(init_busy0), 32'd0);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(1);

    // Byte-enable merge.
    wr(6'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
    wr(6'd5, 32'h11223344, 4'b0101, 1'b0);
    rd(6'd5);
    check("be_merge", rd_data0, 32'hAA22CC44);

    // Same-address read/write collision in both modes.
    wr(6'd9, 32'h0000_00FF, 4'b1111, 1'b0);
    cycle(1'b1, 1'b1, 6'd9, 32'h1234_5678, 4'b1111, 1'b1, 6'd9, 1'b0);
    check("rdw_old", rd_data0, 32'h0000_00FF);
    check("rdw_new", rd_data1, 32'h1234_5678);
    rd(6'd9);
    check("rdw_after_rf", rd_data0, 32'h1234_5678);
    check("rdw_after_wf", rd_data1, 32'h1234_5678);

    // Reset at clear count 30 restarts the full clear.
    do_reset(1);
    idle(30);
    do_reset(1);
    idle(DEPTH);
    check("restart_done", 32'(init_busy0), 32'd0);

    // Reset mid-operation re-zeroes a written word.
    wr(6'd63, 32'h0000_005A, 4'b1111, 1'b0);
    rd(6'd63);
    check("a63_written", rd_data0, 32'h0000_005A);
    do_reset(1);
    idle(DEPTH);
    rd(6'd63);
    check("a63_cleared", rd_data0, 32'h0);

    // Accesses during CLEAR are ignored.
    wr(6'd60, 32'h0000_0033, 4'b1111, 1'b0);
    do_reset(1);
    idle(10);
    cycle(1'b1, 1'b1, 6'd60, 32'h0000_0077, 4'b1111, 1'b1, 6'd60, 1'b0);
    check("clear_no_valid", 32'(rd_valid0), 32'd0);
    idle(DEPTH - 11);
    rd(6'd60);
    check("a60_clear", rd_data0, 32'h0);

`ifdef BRAM_PARITY_EN
    wr(6'd3, 32'h0000_000F, 4'b0001, 1'b1);
    wr(6'd4, 32'h0000_000F, 4'b0001, 1'b0);
    rd(6'd3);
    check("par_inj", 32'(rd_par_err0), 32'h1);
    rd(6'd4);
    check("par_clean", 32'(rd_par_err0), 32'h0);
`endif

    // Randomized traffic with a narrow address window to force collisions, plus rare resets.
    for (int n = 0; n < 2500; n++) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 3));
      cycle(($urandom_range(0, 799) != 0), 1'($urandom), wa, DW'($urandom), NB'($urandom),
            1'($urandom), ra, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
